// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Stage numbering: 0=D, 1=E, 2=M, ..., DEPTH=W.
package pipe_haz_pkg;

    localparam int STG_D = 0;
    localparam int STG_E = 1;
    localparam int STG_M = 2;

    // Forward select value meaning "use the register file operand".
    localparam int FWD_NONE = 0;

    // Tag register-address width; covers register files up to 256 entries.
    localparam int TAG_AW = 8;

    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [TAG_AW-1:0] wa;
        logic              load;
    } tag_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Datapath <-> hazard unit bundle.
// master: datapath side; slave: hazard unit side.
interface pipe_hazard_unit_if #(
    parameter int NRD = 2,
    parameter int AW  = 4,
    parameter int SW  = 2,
    parameter int CW  = 16
);
    logic [NRD-1:0]    rs_valid_d;
    logic [NRD*AW-1:0] rs_addr_d;
    logic              wr_en_d;
    logic [AW-1:0]     wa_d;
    logic              load_d;
    logic              redirect_e;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [NRD*SW-1:0] fwd_sel_e;
    logic [CW-1:0]     stall_cnt;

    modport master (
        output rs_valid_d, rs_addr_d, wr_en_d,
        output wa_d, load_d, redirect_e,
        input  stall_f, stall_d, flush_d,
        input  flush_e, fwd_sel_e, stall_cnt
    );

    modport slave (
        input  rs_valid_d, rs_addr_d, wr_en_d,
        input  wa_d, load_d, redirect_e,
        output stall_f, stall_d, flush_d,
        output flush_e, fwd_sel_e, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit_tag_stage.sv
// One destination-tag register of the shadow pipeline.
// Reset and bubble both leave the stage empty.
module pipe_haz_tag_stage
    import pipe_haz_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bubble,
    input  tag_t d,
    output tag_t q
);

    // Advance the tag one stage, or insert an empty slot.
    always_ff @(posedge clk) begin
        if (!reset || bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the in-order pipeline.
// Macro PIPE_HAZ_FWD_EN enables E-stage forwarding; else stall to W.
module pipe_hazard_unit
    import pipe_haz_pkg::*;
#(
    parameter int NREG      = 16,
    parameter int NRD       = 2,
    parameter int DEPTH     = 3,
    parameter int LOAD_RDY  = 3,
    parameter int NOFWD_REG = 15,
    parameter int CW        = 16,
    localparam int AW       = $clog2(NREG),
    localparam int SW       = sel_width(DEPTH)
) (
    input logic clk,
    input logic reset,
    pipe_hazard_unit_if.slave hz
);

    tag_t              tag_d;
    tag_t              stg [STG_E:DEPTH];
    logic [NRD-1:0]    rs_valid_e;
    logic [NRD*AW-1:0] rs_addr_e;
    logic              lu_win;
    logic              lu_any;
    logic              lu;
    logic [NRD*SW-1:0] fwd;
    logic [CW-1:0]     cnt;

    function automatic logic hit(
        input tag_t          t,
        input logic          v,
        input logic [AW-1:0] r
    );
        return t.valid && t.wr_en && v &&
               (t.wa == TAG_AW'(r)) &&
               (r != AW'(NOFWD_REG));
    endfunction

    // Tag describing the instruction currently in D.
    always_comb begin
        tag_d       = '0;
        tag_d.valid = 1'b1;
        tag_d.wr_en = hz.wr_en_d;
        tag_d.wa    = TAG_AW'(hz.wa_d);
        tag_d.load  = hz.load_d;
    end

    for (genvar s = STG_D + 1; s <= DEPTH; s++) begin : g_stg
        if (s == STG_E) begin : g_e
            pipe_haz_tag_stage u_tag (
                .clk    (clk),
                .reset  (reset),
                .bubble (hz.flush_e),
                .d      (tag_d),
                .q      (stg[s])
            );
        end else begin : g_mw
            pipe_haz_tag_stage u_tag (
                .clk    (clk),
                .reset  (reset),
                .bubble (1'b0),
                .d      (stg[s-1]),
                .q      (stg[s])
            );
        end
    end

    // E-stage sources travel with the E tag; a bubble reads nothing.
    always_ff @(posedge clk) begin
        if (!reset || hz.flush_e) begin
            rs_valid_e <= '0;
        end else begin
            rs_valid_e <= hz.rs_valid_d;
        end
        rs_addr_e <= hz.rs_addr_d;
    end

    // D-source dependencies: any in-flight producer, or a load not yet ready.
    always_comb begin
        lu_win = 1'b0;
        lu_any = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            for (int s = STG_E; s <= DEPTH; s++) begin
                if (hit(stg[s], hz.rs_valid_d[p],
                        hz.rs_addr_d[p*AW +: AW])) begin
                    lu_any = 1'b1;
                    if (stg[s].load && (s <= LOAD_RDY - 2)) begin
                        lu_win = 1'b1;
                    end
                end
            end
        end
    end

    // Forward select per E port; scanning old to young lets youngest win.
    always_comb begin
        fwd = {NRD{SW'(FWD_NONE)}};
        for (int p = 0; p < NRD; p++) begin
            for (int s = DEPTH; s >= STG_M; s--) begin
                if (hit(stg[s], rs_valid_e[p],
                        rs_addr_e[p*AW +: AW])) begin
                    fwd[p*SW +: SW] = SW'(s);
                end
            end
        end
    end

`ifdef PIPE_HAZ_FWD_EN
    logic unused_dep;
    assign unused_dep   = lu_any;
    assign lu           = lu_win;
    assign hz.fwd_sel_e = fwd;
`else
    logic unused_dep;
    assign unused_dep   = lu_win ^ (^fwd);
    assign lu           = lu_any;
    assign hz.fwd_sel_e = '0;
`endif

    // Redirect beats stall: the D instruction is wrong-path.
    assign hz.stall_f = lu & ~hz.redirect_e;
    assign hz.stall_d = lu & ~hz.redirect_e;
    assign hz.flush_e = lu | hz.redirect_e;
    assign hz.flush_d = hz.redirect_e;

    // Saturating count of D stall cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (hz.stall_d && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign hz.stall_cnt = cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed table, corner sequences, random.
// Follows PIPE_HAZ_FWD_EN the same way as the design.
module tb_pipe_hazard_unit;

    localparam int NRD      = 2;
    localparam int AW       = 4;
    localparam int SW       = 2;
    localparam int CW       = 4;
    localparam int DEPTH    = 3;
    localparam int LOAD_RDY = 3;
    localparam int NOFWD    = 15;
    localparam int CMAX     = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_unit_if #(
        .NRD(NRD), .AW(AW), .SW(SW), .CW(CW)
    ) bus ();

    pipe_hazard_unit #(
        .NREG(16), .NRD(NRD), .DEPTH(DEPTH),
        .LOAD_RDY(LOAD_RDY), .NOFWD_REG(NOFWD), .CW(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    typedef struct {
        bit v;
        bit wr;
        int wa;
        bit ld;
        bit rv0;
        bit rv1;
        int ra0;
        int ra1;
    } ins_t;

    typedef struct {
        bit [1:0] rv;
        int ra0;
        int ra1;
        bit we;
        int wa;
        bit ld;
        bit rd;
        bit st;
        bit fd;
        bit fe;
        int fwd;
        int cnt;
    } vec_t;

    // hist[k]: what entered E k cycles ago (so stage k+1 now).
    ins_t hist[$];
    int   mcnt;
    int   checks = 0;
    int   errors = 0;
    ins_t bub;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic ins_t mk(bit [1:0] rv, int ra0, int ra1,
                                bit we, int wa, bit ld);
        ins_t d;
        d.v   = 1;
        d.wr  = we;
        d.wa  = wa;
        d.ld  = ld;
        d.rv0 = rv[0];
        d.rv1 = rv[1];
        d.ra0 = ra0;
        d.ra1 = ra1;
        return d;
    endfunction

    function automatic bit hit(ins_t e, bit v, int r);
        return e.v && e.wr && e.wa == r && v && r != NOFWD;
    endfunction

    function automatic bit model_lu(ins_t d);
        bit lu;
        bit h;
        lu = 0;
        for (int age = 0; age < DEPTH; age++) begin
            h = hit(hist[age], d.rv0, d.ra0) ||
                hit(hist[age], d.rv1, d.ra1);
`ifdef PIPE_HAZ_FWD_EN
            if (h && hist[age].ld && age + 1 <= LOAD_RDY - 2) lu = 1;
`else
            if (h) lu = 1;
`endif
        end
        return lu;
    endfunction

    function automatic int model_fwd();
        int r;
        r = 0;
`ifdef PIPE_HAZ_FWD_EN
        for (int p = 0; p < NRD; p++) begin
            bit v;
            int a;
            int sel;
            v   = (p == 0) ? hist[0].rv0 : hist[0].rv1;
            a   = (p == 0) ? hist[0].ra0 : hist[0].ra1;
            sel = 0;
            for (int s = 2; s <= DEPTH; s++)
                if (sel == 0 && hit(hist[s-1], v, a)) sel = s;
            r = r | (sel << (p * SW));
        end
`endif
        return r;
    endfunction

    task automatic apply(ins_t d, bit redir, bit rst_n);
        reset          = rst_n;
        bus.rs_valid_d = {d.rv1, d.rv0};
        bus.rs_addr_d  = {AW'(d.ra1), AW'(d.ra0)};
        bus.wr_en_d    = d.wr;
        bus.wa_d       = AW'(d.wa);
        bus.load_d     = d.ld;
        bus.redirect_e = redir;
    endtask

    task automatic model_check(ins_t d, bit redir, string nm);
        bit lu;
        lu = model_lu(d);
        chk({nm, ".stall_f"}, 32'(bus.stall_f), 32'(lu && !redir));
        chk({nm, ".stall_d"}, 32'(bus.stall_d), 32'(lu && !redir));
        chk({nm, ".flush_d"}, 32'(bus.flush_d), 32'(redir));
        chk({nm, ".flush_e"}, 32'(bus.flush_e), 32'(lu || redir));
        chk({nm, ".fwd"}, 32'(bus.fwd_sel_e), model_fwd());
        chk({nm, ".cnt"}, 32'(bus.stall_cnt), mcnt);
    endtask

    task automatic advance(ins_t d, bit redir, bit rst_n);
        bit lu;
        ins_t n;
        lu = model_lu(d);
        @(posedge clk);
        if (!rst_n) begin
            hist.delete();
            repeat (DEPTH) hist.push_back(bub);
            mcnt = 0;
        end else begin
            n = (lu || redir) ? bub : d;
            hist.push_front(n);
            void'(hist.pop_back());
            if (lu && !redir && mcnt < CMAX) mcnt++;
        end
        #1;
    endtask

    task automatic step(ins_t d, bit redir, bit rst_n, string nm);
        apply(d, redir, rst_n);
        @(negedge clk);
        model_check(d, redir, nm);
        advance(d, redir, rst_n);
    endtask

    vec_t tab[$];

    initial begin
        ins_t d;
        ins_t nop;
        vec_t tv;
        int   n;

        bub = '{default: 0};
        nop = mk(2'b00, 0, 0, 0, 0, 0);
        hist.delete();
        repeat (DEPTH) hist.push_back(bub);
        mcnt = 0;

        apply(nop, 0, 0);
        @(posedge clk);
        #1;
        step(nop, 0, 0, "rst0");
        step(nop, 0, 1, "rst1");

`ifdef PIPE_HAZ_FWD_EN
        tab.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0});
        tab.push_back('{1, 1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0});
        tab.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0});
        tab.push_back('{0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 3, 0});
        tab.push_back('{2, 0, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0});
        tab.push_back('{2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        tab.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 12, 1});
        tab.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1});
        tab.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        tab.push_back('{0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 2, 1});
        tab.push_back('{1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        tab.push_back('{0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 1});
        tab.push_back('{1, 5, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1});
        tab.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
`else
        tab.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0});
        tab.push_back('{1, 1, 0, 1, 3, 0, 0, 1, 0, 1, 0, 0});
        tab.push_back('{1, 1, 0, 1, 3, 0, 0, 1, 0, 1, 0, 1});
        tab.push_back('{1, 1, 0, 1, 3, 0, 0, 1, 0, 1, 0, 2});
        tab.push_back('{1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 3});
        tab.push_back('{2, 0, 3, 0, 0, 0, 1, 0, 1, 1, 0, 3});
        tab.push_back('{0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 3});
        tab.push_back('{3, 15, 3, 0, 0, 0, 0, 1, 0, 1, 0, 3});
        tab.push_back('{1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4});
        tab.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4});
`endif

        foreach (tab[i]) begin
            tv = tab[i];
            d  = mk(tv.rv, tv.ra0, tv.ra1, tv.we, tv.wa, tv.ld);
            apply(d, tv.rd, 1);
            @(negedge clk);
            chk($sformatf("tab%0d.stall_f", i), 32'(bus.stall_f), 32'(tv.st));
            chk($sformatf("tab%0d.stall_d", i), 32'(bus.stall_d), 32'(tv.st));
            chk($sformatf("tab%0d.flush_d", i), 32'(bus.flush_d), 32'(tv.fd));
            chk($sformatf("tab%0d.flush_e", i), 32'(bus.flush_e), 32'(tv.fe));
            chk($sformatf("tab%0d.fwd", i), 32'(bus.fwd_sel_e), tv.fwd);
            chk($sformatf("tab%0d.cnt", i), 32'(bus.stall_cnt), tv.cnt);
            advance(d, tv.rd, 1);
        end

        // Counter saturation: many producer/consumer stall episodes.
        step(nop, 0, 0, "sat_rst");
        for (int i = 0; i < 20; i++) begin
            step(mk(2'b00, 0, 0, 1, 7, 1), 0, 1, "sat_p");
            n = 0;
            d = mk(2'b01, 7, 0, 0, 0, 0);
            while (model_lu(d) && n < 6) begin
                step(d, 0, 1, "sat_c");
                n++;
            end
            step(d, 0, 1, "sat_go");
        end
        apply(nop, 0, 1);
        @(negedge clk);
        chk("cnt_sat", 32'(bus.stall_cnt), CMAX);
        advance(nop, 0, 1);

        // Reset while a load sits in E with a dependent in D.
        step(mk(2'b00, 0, 0, 1, 8, 1), 0, 1, "mr_ld");
        d = mk(2'b10, 0, 8, 0, 0, 0);
        apply(d, 0, 0);
        @(negedge clk);
        chk("mr_pre_stall", 32'(bus.stall_d), 1);
        advance(d, 0, 0);
        apply(d, 0, 1);
        @(negedge clk);
        chk("mr_stall", 32'(bus.stall_d), 0);
        chk("mr_fwd", 32'(bus.fwd_sel_e), 0);
        chk("mr_cnt", 32'(bus.stall_cnt), 0);
        advance(d, 0, 1);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            int regs[5];
            regs = '{0, 1, 2, 3, 15};
            d = mk(2'($urandom), regs[$urandom_range(0, 4)],
                   regs[$urandom_range(0, 4)], 1'($urandom),
                   regs[$urandom_range(0, 4)], 1'($urandom));
            step(d, ($urandom % 8) == 0, ($urandom % 64) != 0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
